evm_multi_candidate_ballot: RTL and testbench

//  Parametrised electronic voting machine core for NUM_CAND candidates, one vote per issued ballot.
//  A presiding-officer ballot_issue pulse arms the unit for a single vote. Button inputs are synchronised, edge-detected and debounced.

---
 rtl/evm_multi_candidate_ballot.sv | 261 ++++++++++++++++++++++++++
 tb/tb_evm_multi_candidate_ballot.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/evm_multi_candidate_ballot.sv
// Multi-candidate voting core: ballot arming, synchronised/edge-detected buttons, debounce lockout,
// sticky results mode with multiplexed 7-seg readout. Define EVM_TIE_BLINK_EN to blink tied leaders.
module evm_multi_candidate_ballot #(
   parameter int unsigned NUM_CAND     = 3,
   parameter int unsigned MAX_VOTES    = 9,
   parameter int unsigned DEBOUNCE_CYC = 65535,
   parameter int unsigned REFRESH_W    = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                vote_enable,
   input  logic                ballot_issue,
   input  logic [NUM_CAND-1:0] btn,
   output logic [6:0]          display,
   output logic [NUM_CAND-1:0] an,
   output logic [NUM_CAND-1:0] led_win,
   output logic                ready,
   output logic                vote_done,
   output logic                vote_reject,
   output logic                overflow,
   output logic                tie
);

   localparam int unsigned IdxW     = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
   localparam int unsigned DbW      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int unsigned SyncW    = NUM_CAND + 2;
   localparam int unsigned BitIssue = NUM_CAND;
   localparam int unsigned BitVe    = NUM_CAND + 1;

   localparam logic [IdxW-1:0]     LastIdx  = IdxW'(NUM_CAND - 1);
   localparam logic [DbW-1:0]      LastDb   = DbW'(DEBOUNCE_CYC - 1);
   localparam logic [3:0]          MaxCount = 4'(MAX_VOTES);
   localparam logic [NUM_CAND-1:0] OneHot0  = NUM_CAND'(1);

   typedef enum logic [1:0] {StIdle, StArmed, StCooldown, StResults} state_e;

   function automatic logic [6:0] seg7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // ---------------------------------------------------------------------------------------------
   // Input synchronisers and edge detection
   // ---------------------------------------------------------------------------------------------
   logic [SyncW-1:0]    meta_q, sync_q, sync_dly_q;
   logic [NUM_CAND:0]   rise;
   logic [NUM_CAND-1:0] btn_rise_q;
   logic                issue_rise_q;
   logic                ve_fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q       <= '0;
         sync_q       <= '0;
         sync_dly_q   <= '0;
         btn_rise_q   <= '0;
         issue_rise_q <= 1'b0;
      end else begin
         meta_q       <= {vote_enable, ballot_issue, btn};
         sync_q       <= meta_q;
         sync_dly_q   <= sync_q;
         btn_rise_q   <= rise[NUM_CAND-1:0];
         issue_rise_q <= rise[BitIssue];
      end
   end

   assign rise    = sync_q[BitIssue:0] & ~sync_dly_q[BitIssue:0];
   // Close on a falling edge so the cleared synchroniser after reset does not read as "closed".
   assign ve_fall = sync_dly_q[BitVe] & ~sync_q[BitVe];

   // ---------------------------------------------------------------------------------------------
   // Press decode
   // ---------------------------------------------------------------------------------------------
   logic [3:0]      n_press;
   logic [IdxW-1:0] press_idx;

   always_comb begin
      n_press   = '0;
      press_idx = '0;
      for (int i = 0; i < int'(NUM_CAND); i++) begin
         if (btn_rise_q[i]) begin
            n_press   = n_press + 4'd1;
            press_idx = IdxW'(i);
         end
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Ballot FSM
   // ---------------------------------------------------------------------------------------------
   state_e         state_q, state_d;
   logic [DbW-1:0] db_q, db_d;
   logic [3:0]     count_q [NUM_CAND];
   logic [3:0]     sel_count;
   logic           inc_en, sat_hit, done_d, reject_d;
   logic           vote_done_q, vote_reject_q, overflow_q;

   assign sel_count = count_q[press_idx];

   always_comb begin
      state_d  = state_q;
      db_d     = db_q;
      inc_en   = 1'b0;
      sat_hit  = 1'b0;
      done_d   = 1'b0;
      reject_d = 1'b0;
      if (state_q != StResults && ve_fall) begin
         state_d = StResults;
      end else begin
         case (state_q)
            StIdle: begin
               if (issue_rise_q) state_d = StArmed;
            end
            StArmed: begin
               if (n_press == 4'd1) begin
                  done_d  = 1'b1;
                  state_d = StCooldown;
                  db_d    = '0;
                  if (sel_count >= MaxCount) sat_hit = 1'b1;
                  else                       inc_en  = 1'b1;
               end else if (n_press > 4'd1) begin
                  reject_d = 1'b1;
               end
            end
            StCooldown: begin
               if (db_q == LastDb) state_d = StIdle;
               else                db_d    = db_q + DbW'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         db_q          <= '0;
         vote_done_q   <= 1'b0;
         vote_reject_q <= 1'b0;
         overflow_q    <= 1'b0;
         for (int i = 0; i < int'(NUM_CAND); i++) count_q[i] <= '0;
      end else begin
         state_q       <= state_d;
         db_q          <= db_d;
         vote_done_q   <= done_d;
         vote_reject_q <= reject_d;
         if (sat_hit) overflow_q <= 1'b1;
         if (inc_en)  count_q[press_idx] <= sel_count + 4'd1;
      end
   end

   assign ready       = (state_q == StArmed);
   assign vote_done   = vote_done_q;
   assign vote_reject = vote_reject_q;
   assign overflow    = overflow_q;

   // ---------------------------------------------------------------------------------------------
   // Results display scan
   // ---------------------------------------------------------------------------------------------
   logic [REFRESH_W-1:0] ref_q;
   logic [IdxW-1:0]      idx_q;
   logic                 step, wrap;

   assign step = (state_q == StResults) && (&ref_q);
   assign wrap = step && (idx_q == LastIdx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_q <= '0;
         idx_q <= '0;
      end else if (state_q != StResults) begin
         ref_q <= '0;
         idx_q <= '0;
      end else begin
         ref_q <= ref_q + REFRESH_W'(1);
         if (wrap)      idx_q <= '0;
         else if (step) idx_q <= idx_q + IdxW'(1);
      end
   end

   always_comb begin
      display = 7'h7F;
      an      = '1;
      if (state_q == StResults) begin
         an      = ~(OneHot0 << idx_q);
         display = seg7(count_q[idx_q]);
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Winner / tie evaluation
   // ---------------------------------------------------------------------------------------------
   logic [3:0]          max_count, n_lead;
   logic [NUM_CAND-1:0] lead;
   logic [NUM_CAND-1:0] led_q;
   logic                tie_q;

   always_comb begin
      max_count = '0;
      for (int i = 0; i < int'(NUM_CAND); i++) begin
         if (count_q[i] > max_count) max_count = count_q[i];
      end
      lead   = '0;
      n_lead = '0;
      for (int i = 0; i < int'(NUM_CAND); i++) begin
         if (count_q[i] == max_count) begin
            lead[i] = 1'b1;
            n_lead  = n_lead + 4'd1;
         end
      end
   end

`ifdef EVM_TIE_BLINK_EN
   logic blink_q;

   // Leaders start lit on entry and toggle on every scan wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      blink_q <= 1'b1;
      else if (state_q != StResults)   blink_q <= 1'b1;
      else if (wrap)                   blink_q <= ~blink_q;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q <= '0;
         tie_q <= 1'b0;
      end else if (state_q != StResults) begin
         led_q <= '0;
         tie_q <= 1'b0;
      end else begin
         tie_q <= (n_lead > 4'd1);
         if (n_lead == 4'd1) begin
            led_q <= lead;
         end else begin
`ifdef EVM_TIE_BLINK_EN
            led_q <= blink_q ? lead : '0;
`else
            led_q <= '0;
`endif
         end
      end
   end

   assign led_win = led_q;
   assign tie     = tie_q;

endmodule

// File: tb/tb_evm_multi_candidate_ballot.sv
// Directed bench for evm_multi_candidate_ballot: reset, single vote latency, multi-press reject,
// saturation, results scan/winner, tie handling.
`timescale 1ns/1ps
module tb_evm_multi_candidate_ballot;

   localparam int unsigned NumCand     = 3;
   localparam int unsigned MaxVotes    = 9;
   localparam int unsigned DebounceCyc = 4;
   localparam int unsigned RefreshW    = 3;
   localparam int          Dwell       = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vote_enable = 1'b1;
   logic       ballot_issue = 1'b0;
   logic [2:0] btn = '0;
   logic [6:0] display;
   logic [2:0] an;
   logic [2:0] led_win;
   logic       ready, vote_done, vote_reject, overflow, tie;

   int n_checks = 0;
   int n_pass   = 0;
   int d, r, total;

   always #5 clk = ~clk;

   evm_multi_candidate_ballot #(
      .NUM_CAND     (NumCand),
      .MAX_VOTES    (MaxVotes),
      .DEBOUNCE_CYC (DebounceCyc),
      .REFRESH_W    (RefreshW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .vote_enable  (vote_enable),
      .ballot_issue (ballot_issue),
      .btn          (btn),
      .display      (display),
      .an           (an),
      .led_win      (led_win),
      .ready        (ready),
      .vote_done    (vote_done),
      .vote_reject  (vote_reject),
      .overflow     (overflow),
      .tie          (tie)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [6:0] seg_exp(input int v);
      logic [6:0] tbl [10];
      tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
      return tbl[v];
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; vote_enable = 1'b1; ballot_issue = 1'b0; btn = '0;
      tick(2);
      rst_n = 1'b1;
      tick(4);
   endtask

   task automatic issue_ballot();
      ballot_issue = 1'b1;
      tick(2);
      ballot_issue = 1'b0;
      tick(4);
   endtask

   task automatic press(input logic [2:0] mask, output int done, output int rej);
      done = 0; rej = 0;
      btn  = mask;
      for (int c = 0; c < 6; c++) begin
         tick(1);
         if (c == 1) btn = '0;
         done += int'(vote_done);
         rej  += int'(vote_reject);
      end
      tick(6);
   endtask

   task automatic cast_votes(input int cand, input int n, output int done);
      int dd, rr;
      done = 0;
      for (int v = 0; v < n; v++) begin
         issue_ballot();
         press(3'(1 << cand), dd, rr);
         done += dd;
      end
   endtask

   task automatic close_polls();
      vote_enable = 1'b0;
      tick(5);
   endtask

   task automatic read_digits(input string tag, input int c0, input int c1, input int c2);
      check_eq({tag, "_an0"},  32'(an), 32'b110);
      check_eq({tag, "_seg0"}, 32'(display), 32'(seg_exp(c0)));
      tick(Dwell);
      check_eq({tag, "_an1"},  32'(an), 32'b101);
      check_eq({tag, "_seg1"}, 32'(display), 32'(seg_exp(c1)));
      tick(Dwell);
      check_eq({tag, "_an2"},  32'(an), 32'b011);
      check_eq({tag, "_seg2"}, 32'(display), 32'(seg_exp(c2)));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      // T1: reset values, async reset mid-cooldown
      apply_reset();
      check_eq("reset_outs", 32'({display, an, led_win, ready, vote_done, vote_reject, overflow, tie}),
               32'({7'h7F, 3'b111, 3'b000, 5'b0}));
      issue_ballot();
      check_eq("t1_armed_ready", 32'(ready), 32'd1);
      btn = 3'b010;
      tick(5);
      btn = '0;
      check_eq("t1_cooldown_ready", 32'(ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check_eq("t1_async_reset", 32'({display, an, led_win, ready, vote_done, vote_reject, overflow, tie}),
               32'({7'h7F, 3'b111, 3'b000, 5'b0}));
      tick(2);
      rst_n = 1'b1;
      tick(4);
      close_polls();
      check_eq("t1_tie_zero", 32'(tie), 32'd1);
      check_eq("t1_led_zero", 32'(led_win), 32'b000);
      read_digits("t1", 0, 0, 0);

      // T2: single ballot latency, no vote without a new issue
      apply_reset();
      issue_ballot();
      btn = 3'b010;
      tick(1);
      tick(1);
      check_eq("t2_vd_k1", 32'(vote_done), 32'd0);
      tick(1);
      btn = '0;
      check_eq("t2_vd_k2", 32'(vote_done), 32'd0);
      tick(1);
      check_eq("t2_vd_k3", 32'(vote_done), 32'd1);
      check_eq("t2_ready_k3", 32'(ready), 32'd0);
      tick(1);
      check_eq("t2_vd_k4", 32'(vote_done), 32'd0);
      tick(8);
      press(3'b010, d, r);
      check_eq("t2_no_reissue", 32'(d), 32'd0);
      close_polls();
      check_eq("t2_led", 32'(led_win), 32'b010);
      check_eq("t2_tie", 32'(tie), 32'd0);
      read_digits("t2", 0, 1, 0);

      // T3: multi-press rejected, ballot stays armed
      apply_reset();
      issue_ballot();
      press(3'b101, d, r);
      check_eq("t3_reject", 32'(r), 32'd1);
      check_eq("t3_no_done", 32'(d), 32'd0);
      check_eq("t3_ready", 32'(ready), 32'd1);
      press(3'b100, d, r);
      check_eq("t3_done", 32'(d), 32'd1);
      close_polls();
      check_eq("t3_led", 32'(led_win), 32'b100);
      read_digits("t3", 0, 0, 1);

      // T4: saturation at MAX_VOTES
      apply_reset();
      cast_votes(0, 9, total);
      check_eq("t4_ovf_before", 32'(overflow), 32'd0);
      cast_votes(0, 1, d);
      total += d;
      check_eq("t4_ovf_after", 32'(overflow), 32'd1);
      check_eq("t4_done_count", 32'(total), 32'd10);
      close_polls();
      check_eq("t4_led", 32'(led_win), 32'b001);
      check_eq("t4_ovf_sticky", 32'(overflow), 32'd1);
      read_digits("t4", 9, 0, 0);

      // T5: results scan, winner, sticky RESULTS
      apply_reset();
      cast_votes(0, 3, d);
      cast_votes(1, 5, d);
      cast_votes(2, 2, d);
      close_polls();
      check_eq("t5_led", 32'(led_win), 32'b010);
      check_eq("t5_tie", 32'(tie), 32'd0);
      read_digits("t5", 3, 5, 2);
      tick(Dwell);
      check_eq("t5_wrap_an", 32'(an), 32'b110);
      check_eq("t5_wrap_seg", 32'(display), 32'(seg_exp(3)));
      vote_enable = 1'b1;
      tick(6);
      check_eq("t5_sticky_an", 32'(an), 32'b101);
      check_eq("t5_sticky_led", 32'(led_win), 32'b010);

      // T6: tie between candidates 0 and 1
      apply_reset();
      cast_votes(0, 4, d);
      cast_votes(1, 4, d);
      cast_votes(2, 1, d);
      close_polls();
      check_eq("t6_tie", 32'(tie), 32'd1);
`ifdef EVM_TIE_BLINK_EN
      check_eq("t6_led_entry", 32'(led_win), 32'b011);
`else
      check_eq("t6_led_entry", 32'(led_win), 32'b000);
`endif
      read_digits("t6", 4, 4, 1);
      tick(Dwell);
      check_eq("t6_led_wrap1", 32'(led_win), 32'b000);
      tick(3 * Dwell);
`ifdef EVM_TIE_BLINK_EN
      check_eq("t6_led_wrap2", 32'(led_win), 32'b011);
`else
      check_eq("t6_led_wrap2", 32'(led_win), 32'b000);
`endif
      check_eq("t6_tie_hold", 32'(tie), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
